// File: rtl/dot_feeder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dot_feeder_pkg : state type, MAC sum constants, width helpers     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package dot_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int MAC_SUM_W   = 14;
  localparam int MAC_SUM_MAX = (1 << MAC_SUM_W) - 1;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot_feeder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dot_feeder_if : buffer write, start and MAC-drive signal bundle   |
// | ovf exists only with DOT_FEEDER_OVF_EN.  Revision 1.0             |
// +------------------------------------------------------------------+
interface dot_feeder_if
  import dot_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
);
  logic                      wr_en;
  logic [idx_w(DEPTH)-1:0]   wr_addr;
  logic [W-1:0]              wr_a;
  logic [W-1:0]              wr_b;
  logic                      start;
  logic [len_w(DEPTH)-1:0]   len;
  logic                      busy;
  logic                      mac_clear;
  logic [W-1:0]              a_out;
  logic [W-1:0]              b_out;
  logic                      done;
`ifdef DOT_FEEDER_OVF_EN
  logic                      ovf;

  modport master (
    output wr_en, wr_addr, wr_a, wr_b, start, len,
    input  busy, mac_clear, a_out, b_out, done, ovf
  );
  modport slave (
    input  wr_en, wr_addr, wr_a, wr_b, start, len,
    output busy, mac_clear, a_out, b_out, done, ovf
  );
`else
  modport master (
    output wr_en, wr_addr, wr_a, wr_b, start, len,
    input  busy, mac_clear, a_out, b_out, done
  );
  modport slave (
    input  wr_en, wr_addr, wr_a, wr_b, start, len,
    output busy, mac_clear, a_out, b_out, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/dot_feeder_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dot_feeder_buf : paired operand register arrays, one write port, |
// | combinational read.  Revision 1.0                                 |
// +------------------------------------------------------------------+
module dot_feeder_buf
  import dot_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     i_we,
  input  wire logic [idx_w(DEPTH)-1:0]  i_waddr,
  input  wire logic [W-1:0]             i_wa,
  input  wire logic [W-1:0]             i_wb,
  input  wire logic [idx_w(DEPTH)-1:0]  i_raddr,
  output logic      [W-1:0]             o_ra,
  output logic      [W-1:0]             o_rb
);
  logic [W-1:0] r_a [DEPTH];
  logic [W-1:0] r_b [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (i_we) begin
      r_a[i_waddr] <= i_wa;
      r_b[i_waddr] <= i_wb;
    end
  end

  assign o_ra = r_a[i_raddr];
  assign o_rb = r_b[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dot_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dot_feeder : sequences clear + operand stream into the dot MAC.   |
// | Optional exact-sum overflow flag: DOT_FEEDER_OVF_EN. Rev 1.0      |
// +------------------------------------------------------------------+
module dot_feeder
  import dot_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  wire logic   clock,
  input  wire logic   reset,
  dot_feeder_if.slave bus
);
  localparam int c_IW = idx_w(DEPTH);
  localparam int c_LW = len_w(DEPTH);

  state_t          r_state;
  logic [c_LW-1:0] r_len;
  logic [c_LW-1:0] r_cnt;
  logic            r_busy;
  logic            r_mac_clear;
  logic            r_done;
  logic [W-1:0]    r_a_out;
  logic [W-1:0]    r_b_out;

  logic [W-1:0]    w_rd_a;
  logic [W-1:0]    w_rd_b;
  logic            w_we;
  logic [c_LW-1:0] w_len_cl;

  assign w_we     = bus.wr_en && (r_state == S_IDLE);
  assign w_len_cl = (bus.len > c_LW'(DEPTH)) ? c_LW'(DEPTH) : bus.len;

  dot_feeder_buf #(.DEPTH(DEPTH), .W(W)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (bus.wr_addr),
    .i_wa    (bus.wr_a),
    .i_wb    (bus.wr_b),
    .i_raddr (r_cnt[c_IW-1:0]),
    .o_ra    (w_rd_a),
    .o_rb    (w_rd_b)
  );

  // Outputs are set from the next state so they line up with it; the MAC
  // sees zeros in every non-stream cycle and therefore holds its sum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_mac_clear <= 1'b1;
      r_done      <= 1'b0;
      r_a_out     <= '0;
      r_b_out     <= '0;
    end else begin
      r_a_out     <= '0;
      r_b_out     <= '0;
      r_mac_clear <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_CLEAR;
            r_len       <= w_len_cl;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_mac_clear <= 1'b1;
          end
        end
        S_CLEAR, S_STREAM: begin
          if (r_cnt == r_len) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_STREAM;
            r_a_out <= w_rd_a;
            r_b_out <= w_rd_b;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.mac_clear = r_mac_clear;
  assign bus.done      = r_done;
  assign bus.a_out     = r_a_out;
  assign bus.b_out     = r_b_out;

`ifdef DOT_FEEDER_OVF_EN
  localparam int c_SW = 2 * W + c_IW;

  logic [c_SW-1:0] r_shadow;
  logic [c_SW-1:0] w_shadow_next;
  logic            r_ovf;

  // The shadow adds the pair presented this cycle, mirroring the MAC edge.
  assign w_shadow_next = r_shadow + (c_SW'(r_a_out) * c_SW'(r_b_out));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_STREAM) begin
      r_shadow <= w_shadow_next;
      if (r_cnt == r_len) begin
        r_ovf <= (w_shadow_next > c_SW'(MAC_SUM_MAX));
      end
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dot_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dot_feeder : randomized directed bench with a reference MAC    |
// | and array model.  Revision 1.0                                    |
// +------------------------------------------------------------------+
module tb_dot_feeder;
  localparam int DEPTH = 8;
  localparam int W     = 8;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   ref_a [DEPTH];
  int   ref_b [DEPTH];
  logic [13:0] mac_s;

  dot_feeder_if #(.DEPTH(DEPTH), .W(W)) bus ();

  dot_feeder #(.DEPTH(DEPTH), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream MAC: 14-bit wrapping accumulator with synchronous clear.
  always_ff @(posedge clock) begin
    if (bus.mac_clear) mac_s <= '0;
    else mac_s <= mac_s + 14'(int'(bus.a_out) * int'(bus.b_out));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int a, input int b);
    @(negedge clock);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_a    = 8'(a);
    bus.wr_b    = 8'(b);
    ref_a[addr] = a;
    ref_b[addr] = b;
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic noise_drive(input bit en);
    bus.start   = en;
    bus.len     = 4'($urandom_range(0, 15));
    bus.wr_en   = en;
    bus.wr_addr = 3'($urandom_range(0, DEPTH - 1));
    bus.wr_a    = 8'($urandom);
    bus.wr_b    = 8'($urandom);
  endtask

  // One full operation, checked cycle by cycle from start to the idle cycle.
  task automatic do_op(input int l, input bit noise, input bit sw,
                       input int swaddr, input int swa, input int swb);
    int lc;
    int exact;
    lc = (l > DEPTH) ? DEPTH : l;
    @(negedge clock);
    bus.start = 1'b1;
    bus.len   = 4'(l);
    if (sw) begin
      bus.wr_en     = 1'b1;
      bus.wr_addr   = 3'(swaddr);
      bus.wr_a      = 8'(swa);
      bus.wr_b      = 8'(swb);
      ref_a[swaddr] = swa;
      ref_b[swaddr] = swb;
    end
    exact = 0;
    for (int k = 0; k < lc; k++) exact += ref_a[k] * ref_b[k];
    @(negedge clock);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("clear_busy", 32'(bus.busy), 1);
    chk("clear_mac_clear", 32'(bus.mac_clear), 1);
    chk("clear_a_out", 32'(bus.a_out), 0);
    chk("clear_done", 32'(bus.done), 0);
    noise_drive(noise);
    for (int k = 0; k < lc; k++) begin
      @(negedge clock);
      chk("stream_a", 32'(bus.a_out), 32'(ref_a[k]));
      chk("stream_b", 32'(bus.b_out), 32'(ref_b[k]));
      chk("stream_mac_clear", 32'(bus.mac_clear), 0);
      chk("stream_done", 32'(bus.done), 0);
      chk("stream_busy", 32'(bus.busy), 1);
      noise_drive(noise);
    end
    @(negedge clock);
    noise_drive(1'b0);
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 1);
    chk("done_a_out", 32'(bus.a_out), 0);
    chk("done_sum", 32'(mac_s), 32'(exact % 16384));
`ifdef DOT_FEEDER_OVF_EN
    chk("done_ovf", 32'(bus.ovf), 32'(exact > 16383));
`endif
    @(negedge clock);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_sum_held", 32'(mac_s), 32'(exact % 16384));
`ifdef DOT_FEEDER_OVF_EN
    chk("idle_ovf_hold", 32'(bus.ovf), 32'(exact > 16383));
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int k = 0; k < DEPTH; k++) begin
      ref_a[k] = 0;
      ref_b[k] = 0;
    end
    reset = 1'b1;
    noise_drive(1'b0);
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_a_out", 32'(bus.a_out), 0);
    chk("rst_mac_clear", 32'(bus.mac_clear), 1);
`ifdef DOT_FEEDER_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 0);
`endif
    reset = 1'b0;
    @(negedge clock);
    chk("idle_mac_clear", 32'(bus.mac_clear), 0);

    // Basic sum 2*3 + 4*6 + 8*3 = 54
    wr(0, 2, 3);
    wr(1, 4, 6);
    wr(2, 8, 3);
    do_op(3, 1'b0, 1'b0, 0, 0, 0);
    do_op(0, 1'b0, 1'b0, 0, 0, 0);

    // Wrap: 255*255 = 65025 -> 15873
    wr(0, 255, 255);
    do_op(1, 1'b0, 1'b0, 0, 0, 0);

    // Ignored start/wr_en while busy, then a clean rerun
    wr(0, 2, 3);
    do_op(3, 1'b1, 1'b0, 0, 0, 0);
    do_op(3, 1'b0, 1'b0, 0, 0, 0);

    // Write in the same cycle as start
    do_op(3, 1'b0, 1'b1, 2, 100, 7);

    // Full length and clamping
    for (int k = 0; k < DEPTH; k++) wr(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    do_op(9, 1'b0, 1'b0, 0, 0, 0);
    do_op(8, 1'b1, 1'b0, 0, 0, 0);

    // Randomized operations
    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < 3; j++)
        wr(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      do_op(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)));
    end

    // Mid-operation reset in the third cycle after start
    for (int k = 0; k < DEPTH; k++) wr(k, k + 1, k + 2);
    @(negedge clock);
    bus.start = 1'b1;
    bus.len   = 4'd8;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre_rst_a_out", 32'(bus.a_out), 32'(ref_a[1]));
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_a_out", 32'(bus.a_out), 0);
    chk("mid_rst_b_out", 32'(bus.b_out), 0);
    chk("mid_rst_mac_clear", 32'(bus.mac_clear), 1);
    @(negedge clock);
    chk("mid_rst_sum", 32'(mac_s), 0);
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      ref_a[k] = 0;
      ref_b[k] = 0;
    end
    do_op(4, 1'b0, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
